// File: rtl/jts16_scr_mmr_if.sv
// CPU-side bus of the scroll register window: select, direction, word address,
// active-low byte strobes, write data and registered read data.
interface jts16_scr_mmr_if;
    logic        cpu_cs;
    logic        cpu_we;
    logic [2:0]  cpu_addr;
    logic [1:0]  cpu_dsn;
    logic [15:0] cpu_dout;
    logic [15:0] cpu_din;

    modport master (
        output cpu_cs, cpu_we, cpu_addr, cpu_dsn, cpu_dout,
        input  cpu_din
    );

    modport slave (
        input  cpu_cs, cpu_we, cpu_addr, cpu_dsn, cpu_dout,
        output cpu_din
    );
endinterface

// File: rtl/jts16_scr_mmr.sv
// Scroll register window for both tilemap layers: the CPU writes shadow regs, and
// the layers see the active copy, which is refreshed only on blanking edges.
module jts16_scr_mmr #(
    parameter bit          SHADOW   = 1'b1,
    parameter logic [15:0] PAGE_RST = 16'h0123
) (
    input  logic           clk,
    input  logic           rst_n,
    jts16_scr_mmr_if.slave cpu,
    input  logic           LVBL,
    input  logic           LHBL,
    output logic [15:0]    scr1_pages,
    output logic [15:0]    scr1_hscr,
    output logic [15:0]    scr1_vscr,
    output logic [15:0]    scr2_pages,
    output logic [15:0]    scr2_hscr,
    output logic [15:0]    scr2_vscr,
    output logic           flip,
    output logic           line_mode
);

    // Word order matches the CPU map: pages1, pages2, hscr1, hscr2, vscr1, vscr2
    logic [15:0] sh_q  [6];
    logic [15:0] sh_d  [6];
    logic [15:0] act_q [6];
    logic [15:0] act_d [6];
    logic [1:0]  ctrl_q, ctrl_d;
    logic        flip_q, flip_d;
    logic        lmode_q, lmode_d;
    logic        pending_q, pending_d;
    logic [15:0] din_q, din_d;
    logic        vb_q, vb_d;
    logic        hb_q, hb_d;
    logic        latch_q, latch_d;
    logic        latch_v_q, latch_v_d;
    logic        wr_en;

    always_comb begin
        sh_d      = sh_q;
        ctrl_d    = ctrl_q;
        act_d     = act_q;
        flip_d    = flip_q;
        lmode_d   = lmode_q;
        pending_d = pending_q;
        din_d     = din_q;
        // Blank flags are stored inverted and reset to 1, so a low level
        // present at reset release only counts once a high has been seen.
        vb_d      = ~LVBL;
        hb_d      = ~LHBL;
        latch_v_d = ~vb_q & ~LVBL;
        latch_d   = latch_v_d | (ctrl_q[1] & ~hb_q & ~LHBL);
        wr_en     = cpu.cpu_cs & cpu.cpu_we & (cpu.cpu_addr != 3'd7);

        if (wr_en) begin
            if (cpu.cpu_addr == 3'd6) begin
                if (!cpu.cpu_dsn[0]) ctrl_d = cpu.cpu_dout[1:0];
            end else begin
                if (!cpu.cpu_dsn[1]) sh_d[cpu.cpu_addr][15:8] = cpu.cpu_dout[15:8];
                if (!cpu.cpu_dsn[0]) sh_d[cpu.cpu_addr][7:0]  = cpu.cpu_dout[7:0];
            end
        end

        if (cpu.cpu_cs && !cpu.cpu_we) begin
            case (cpu.cpu_addr)
                3'd7:    din_d = {13'd0, LHBL, LVBL, pending_q};
                3'd6:    din_d = {14'd0, ctrl_q};
                default: din_d = sh_q[cpu.cpu_addr];
            endcase
        end

        if (SHADOW) begin
            // Copy uses the registered shadow, so a write on the latch clk stays pending
            if (latch_q) begin
                act_d     = sh_q;
                pending_d = 1'b0;
                if (latch_v_q) begin
                    flip_d  = ctrl_q[0];
                    lmode_d = ctrl_q[1];
                end
            end
            if (wr_en && cpu.cpu_dsn != 2'b11) pending_d = 1'b1;
        end else begin
            act_d     = sh_q;
            flip_d    = ctrl_q[0];
            lmode_d   = ctrl_q[1];
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 6; i++) begin
                sh_q[i]  <= (i < 2) ? PAGE_RST : '0;
                act_q[i] <= (i < 2) ? PAGE_RST : '0;
            end
            ctrl_q    <= '0;
            flip_q    <= 1'b0;
            lmode_q   <= 1'b0;
            pending_q <= 1'b0;
            din_q     <= '0;
            vb_q      <= 1'b1;
            hb_q      <= 1'b1;
            latch_q   <= 1'b0;
            latch_v_q <= 1'b0;
        end else begin
            sh_q      <= sh_d;
            act_q     <= act_d;
            ctrl_q    <= ctrl_d;
            flip_q    <= flip_d;
            lmode_q   <= lmode_d;
            pending_q <= pending_d;
            din_q     <= din_d;
            vb_q      <= vb_d;
            hb_q      <= hb_d;
            latch_q   <= latch_d;
            latch_v_q <= latch_v_d;
        end
    end

    assign cpu.cpu_din = din_q;
    assign scr1_pages  = act_q[0];
    assign scr2_pages  = act_q[1];
    assign scr1_hscr   = act_q[2];
    assign scr2_hscr   = act_q[3];
    assign scr1_vscr   = act_q[4];
    assign scr2_vscr   = act_q[5];
    assign flip        = flip_q;
    assign line_mode   = lmode_q;

endmodule

// File: tb/tb_jts16_scr_mmr.sv
// Directed bench for jts16_scr_mmr: a shadowed instance and a SHADOW=0 instance
// sharing clock and blanking inputs, checked against hand-computed values.
module tb_jts16_scr_mmr;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic LVBL  = 1'b1;
    logic LHBL  = 1'b1;
    always #5 clk = ~clk;

    jts16_scr_mmr_if a_if ();
    jts16_scr_mmr_if b_if ();

    logic [15:0] a_p1, a_p2, a_h1, a_h2, a_v1, a_v2;
    logic [15:0] b_p1, b_p2, b_h1, b_h2, b_v1, b_v2;
    logic        a_flip, a_lm, b_flip, b_lm;
    logic [15:0] d;
    int          n_tests = 0;
    int          n_fail  = 0;

    jts16_scr_mmr #(.SHADOW(1'b1), .PAGE_RST(16'h0123)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .cpu(a_if), .LVBL(LVBL), .LHBL(LHBL),
        .scr1_pages(a_p1), .scr1_hscr(a_h1), .scr1_vscr(a_v1),
        .scr2_pages(a_p2), .scr2_hscr(a_h2), .scr2_vscr(a_v2),
        .flip(a_flip), .line_mode(a_lm)
    );

    jts16_scr_mmr #(.SHADOW(1'b0), .PAGE_RST(16'h0123)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .cpu(b_if), .LVBL(LVBL), .LHBL(LHBL),
        .scr1_pages(b_p1), .scr1_hscr(b_h1), .scr1_vscr(b_v1),
        .scr2_pages(b_p2), .scr2_hscr(b_h2), .scr2_vscr(b_v2),
        .flip(b_flip), .line_mode(b_lm)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        a_if.cpu_cs = 1'b0; a_if.cpu_we = 1'b0;
        b_if.cpu_cs = 1'b0; b_if.cpu_we = 1'b0;
    endtask

    task automatic drive(input bit b, input bit we, input logic [2:0] addr,
                         input logic [15:0] data, input logic [1:0] dsn);
        if (b) begin
            b_if.cpu_cs = 1'b1; b_if.cpu_we = we; b_if.cpu_addr = addr;
            b_if.cpu_dout = data; b_if.cpu_dsn = dsn;
        end else begin
            a_if.cpu_cs = 1'b1; a_if.cpu_we = we; a_if.cpu_addr = addr;
            a_if.cpu_dout = data; a_if.cpu_dsn = dsn;
        end
    endtask

    task automatic wr(input bit b, input logic [2:0] addr, input logic [15:0] data,
                      input logic [1:0] dsn);
        @(negedge clk);
        drive(b, 1'b1, addr, data, dsn);
        @(negedge clk);
        bus_idle();
    endtask

    task automatic rd(input bit b, input logic [2:0] addr, output logic [15:0] data);
        @(negedge clk);
        drive(b, 1'b0, addr, 16'h0000, 2'b00);
        @(negedge clk);
        bus_idle();
        data = b ? b_if.cpu_din : a_if.cpu_din;
    endtask

    task automatic vblank();
        @(negedge clk); LVBL = 1'b0;
        repeat (3) @(negedge clk);
        LVBL = 1'b1;
        @(negedge clk);
    endtask

    task automatic hblank();
        @(negedge clk); LHBL = 1'b0;
        repeat (3) @(negedge clk);
        LHBL = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        a_if.cpu_addr = '0; a_if.cpu_dout = '0; a_if.cpu_dsn = 2'b11;
        b_if.cpu_addr = '0; b_if.cpu_dout = '0; b_if.cpu_dsn = 2'b11;
        bus_idle();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset state
        check("rst_p1", a_p1, 16'h0123);
        check("rst_p2", a_p2, 16'h0123);
        check("rst_h1", a_h1, 16'h0000);
        check("rst_v2", a_v2, 16'h0000);
        check("rst_flip", 16'(a_flip), 16'h0000);
        rd(0, 3'd7, d); check("rst_status", d, 16'h0006);
        rd(0, 3'd0, d); check("rst_rd_p1", d, 16'h0123);

        // shadow write, then LVBL fall
        wr(0, 3'd2, 16'h01A5, 2'b00);
        repeat (2) @(negedge clk);
        check("sh_h1_held", a_h1, 16'h0000);
        rd(0, 3'd7, d); check("sh_pending", d, 16'h0007);
        @(negedge clk); LVBL = 1'b0;
        @(negedge clk); check("sh_h1_1clk", a_h1, 16'h0000);
        @(negedge clk); check("sh_h1_2clk", a_h1, 16'h01A5);
        rd(0, 3'd7, d); check("sh_status_vb", d, 16'h0004);
        @(negedge clk); LVBL = 1'b1;

        // byte strobes
        wr(0, 3'd3, 16'h1234, 2'b00);
        wr(0, 3'd3, 16'hABCD, 2'b01);
        rd(0, 3'd3, d); check("be_hi", d, 16'hAB34);
        wr(0, 3'd3, 16'hFFFF, 2'b11);
        rd(0, 3'd3, d); check("be_none", d, 16'hAB34);
        wr(0, 3'd3, 16'h00EF, 2'b10);
        rd(0, 3'd3, d); check("be_lo", d, 16'hABEF);
        wr(0, 3'd7, 16'hFFFF, 2'b00);
        rd(0, 3'd7, d); check("st_ro", d, 16'h0007);
        check("be_h2_held", a_h2, 16'h0000);
        vblank();
        check("be_h2_latched", a_h2, 16'hABEF);
        check("be_h1_kept", a_h1, 16'h01A5);
        rd(0, 3'd7, d); check("be_status", d, 16'h0006);

        // line mode
        wr(0, 3'd6, 16'hFFFF, 2'b00);
        rd(0, 3'd6, d); check("ctrl_mask", d, 16'h0003);
        wr(0, 3'd6, 16'h0002, 2'b00);
        vblank();
        check("lm_on", 16'(a_lm), 16'h0001);
        check("lm_flip0", 16'(a_flip), 16'h0000);
        wr(0, 3'd4, 16'h0010, 2'b00);
        hblank();
        check("lm_v1_hb", a_v1, 16'h0010);
        rd(0, 3'd7, d); check("lm_status", d, 16'h0006);
        wr(0, 3'd6, 16'h0000, 2'b00);
        wr(0, 3'd4, 16'h0020, 2'b00);
        hblank();
        check("lm_off_v1", a_v1, 16'h0010);
        vblank();
        check("lm_off_v1_vb", a_v1, 16'h0020);
        check("lm_off", 16'(a_lm), 16'h0000);
        wr(0, 3'd6, 16'h0003, 2'b00);
        hblank();
        check("flip_hb", 16'(a_flip), 16'h0000);
        check("lm_hb", 16'(a_lm), 16'h0000);
        vblank();
        check("flip_vb", 16'(a_flip), 16'h0001);
        check("lm_vb", 16'(a_lm), 16'h0001);
        wr(0, 3'd6, 16'h0000, 2'b00);
        vblank();
        check("flip_clr", 16'(a_flip), 16'h0000);

        // write on the latch clk
        wr(0, 3'd5, 16'h0033, 2'b00);
        vblank();
        check("col_pre", a_v2, 16'h0033);
        @(negedge clk); LVBL = 1'b0;
        @(negedge clk); drive(0, 1'b1, 3'd5, 16'h0055, 2'b00);
        @(negedge clk); bus_idle();
        check("col_v2_old", a_v2, 16'h0033);
        rd(0, 3'd7, d); check("col_pending", d, 16'h0005);
        rd(0, 3'd5, d); check("col_shadow", d, 16'h0055);
        @(negedge clk); LVBL = 1'b1;
        vblank();
        check("col_v2_new", a_v2, 16'h0055);
        rd(0, 3'd7, d); check("col_status", d, 16'h0006);

        // mid-frame reset with a latch in flight
        wr(0, 3'd2, 16'h7777, 2'b00);
        vblank();
        check("mr_h1_pre", a_h1, 16'h7777);
        wr(0, 3'd0, 16'hAAAA, 2'b00);
        @(negedge clk); LVBL = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("mr_async_h1", a_h1, 16'h0000);
        check("mr_async_p1", a_p1, 16'h0123);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mr_p1", a_p1, 16'h0123);
        check("mr_h1", a_h1, 16'h0000);
        check("mr_v2", a_v2, 16'h0000);
        rd(0, 3'd0, d); check("mr_rd_p1", d, 16'h0123);
        rd(0, 3'd7, d); check("mr_status", d, 16'h0004);
        wr(0, 3'd2, 16'h1111, 2'b00);
        repeat (3) @(negedge clk);
        check("mr_no_edge", a_h1, 16'h0000);
        rd(0, 3'd7, d); check("mr_pending", d, 16'h0005);
        @(negedge clk); LVBL = 1'b1;
        vblank();
        check("mr_h1_vb", a_h1, 16'h1111);

        // SHADOW=0 instance
        wr(1, 3'd0, 16'h4567, 2'b00);
        check("ns_p1_0clk", b_p1, 16'h0123);
        @(negedge clk); check("ns_p1_1clk", b_p1, 16'h4567);
        check("ns_p2", b_p2, 16'h0123);
        rd(1, 3'd7, d); check("ns_status", d, 16'h0006);
        wr(1, 3'd2, 16'hABCD, 2'b10);
        @(negedge clk); check("ns_h1_lo", b_h1, 16'h00CD);
        wr(1, 3'd6, 16'h0001, 2'b00);
        @(negedge clk); check("ns_flip", 16'(b_flip), 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
